// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    // A new session may only begin from a resting state.
    function automatic logic start_allowed(input state_e s);
        return s inside {StIdle, StDone, StError};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: bytes shift in from the top so the first byte lands in [7:0].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic [7:0]                  byte_i,
    input  logic                        valid_i,
    output logic [BYTES_PER_WORD*8-1:0] word_o,
    output logic                        word_full_o
);

    localparam int unsigned WordW = BYTES_PER_WORD * 8;
    localparam int unsigned IdxW  = $clog2(BYTES_PER_WORD);

    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WordW-1:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (valid_i) begin
            idx_d  = IdxW'(idx_q + 1'b1);
            word_d = {byte_i, word_q[WordW-1:8]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = valid_i && !clr_i && (idx_q == IdxW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive 32-bit instruction memory writes.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2048
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic [WIDTH-1:0] mem_address_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic             mem_we_o,
    output logic             cpu_hold_o,
    output logic             done_o,
    output logic             error_o,
    output logic [15:0]      words_loaded_o
);

    localparam int unsigned LenW  = LEN_BYTES * 8;
    localparam int unsigned WordW = BYTES_PER_WORD * 8;

    state_e           state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [LenW-1:0]  len_q, len_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [15:0]      words_q, words_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             xfer;
    logic             data_xfer;
    logic             start_acc;
    logic             word_full;
    logic [WordW-1:0] packed_word;
    logic [LenW-1:0]  len_rx;

    assign rx_ready_o = state_q inside {StLenLo, StLenHi, StData, StCheck};
    assign xfer       = rx_valid_i && rx_ready_o;
    assign data_xfer  = xfer && (state_q == StData);
    assign start_acc  = start_i && start_allowed(state_q);
    assign len_rx     = {rx_data_i, len_lo_q};

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_acc),
        .byte_i      (rx_data_i),
        .valid_i     (data_xfer),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (data_xfer) begin
            csum_d = csum_q ^ rx_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    localparam state_e StAfterData = StCheck;
`else
    localparam state_e StAfterData = StDone;
`endif

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        addr_d   = addr_q;
        words_d  = words_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        error_d  = error_q;

        if (start_acc) begin
            state_d = StLenLo;
            addr_d  = '0;
            words_d = '0;
            hold_d  = 1'b1;
            error_d = 1'b0;
        end else begin
            case (state_q)
                StLenLo: begin
                    if (xfer) begin
                        len_lo_d = rx_data_i;
                        state_d  = StLenHi;
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        len_d = len_rx;
                        if (len_rx == '0) begin
                            state_d = StAfterData;
                        end else if (32'(len_rx) > DEPTH) begin
                            state_d = StError;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (word_full) begin
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    addr_d  = addr_q + WIDTH'(BYTES_PER_WORD);
                    words_d = words_q + 16'd1;
                    if ((words_q + 16'd1) == 16'(len_q)) begin
                        state_d = StAfterData;
                    end else begin
                        state_d = StData;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (xfer) begin
                        state_d = (rx_data_i == csum_q) ? StDone : StError;
                    end
                end
`endif
                default: ;
            endcase
        end

        // done and the cpu_hold release share the DONE entry cycle.
        if (state_d == StDone && state_q != StDone) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        if (state_d == StError && state_q != StError) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            len_lo_q <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            words_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign mem_we_o       = (state_q == StWrite);
    assign mem_address_o  = addr_q;
    assign mem_wdata_o    = WIDTH'(packed_word);
    assign cpu_hold_o     = hold_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the write-side counterpart of the core's asynchronous word-addressed instruction memory. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them to consecutive word addresses through the instruction memory's write port. While loading, the CPU is held in reset.

## Interface
- WIDTH, 32, data and address width; byte address, word index is `address[WIDTH-1:2]`.
- DEPTH, 2048, instruction memory depth in words; the upper bound for the load length.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load session; honoured only in IDLE, DONE or ERROR.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts the byte this cycle.
- mem_address  out  WIDTH  byte address of the write; always word-aligned (bits [1:0] = 0).
- mem_wdata  out  WIDTH  packed instruction word.
- mem_we  out  1  write strobe, one cycle per word.
- cpu_hold  out  1  CPU reset request; high while not successfully loaded.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag; cleared by the next accepted start.
- words_loaded  out  16  count of words written in the current session.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes, least-significant byte of each word first.
- A byte transfer occurs when rx_valid and rx_ready are both high in the same cycle. Only transfers advance state.
- States and transitions:
  - IDLE: start → LEN_LO.
  - LEN_LO: transfer → LEN_HI.
  - LEN_HI: on transfer:
    - N = 0 → DONE.
    - N > DEPTH → ERROR.
    - otherwise → DATA.
  - DATA: the 4th byte of a word → WRITE.
  - WRITE: one cycle, then:
    - another word remains → DATA.
    - last word → DONE (or CHECK, see Configuration).
  - DONE: start → LEN_LO. ERROR: start → LEN_LO.
- rx_ready is 1 only in LEN_LO, LEN_HI, DATA and CHECK. It is 0 in WRITE, IDLE, DONE and ERROR.
- Address: starts at 0 on each accepted start and advances by 4 after every WRITE. It never wraps, because N ≤ DEPTH.
- words_loaded is cleared on start and increments on each WRITE.
- cpu_hold:
  - Set to 1 on start.
  - Cleared on entry to DONE.
  - Stays 1 in ERROR.
- done pulses for exactly one cycle on entry to DONE.
- error is set on entry to ERROR.
- A start asserted during LEN_LO, LEN_HI, DATA, WRITE or CHECK is ignored.

## Timing
- Reset values:
  - state IDLE
  - rx_ready 0, mem_we 0, mem_address 0, mem_wdata 0
  - cpu_hold 1, done 0, error 0, words_loaded 0
- Reset mid-session aborts immediately. No further writes occur, and partially packed bytes are discarded.
- Write latency: mem_we rises in the cycle after the 4th byte's transfer. mem_address and mem_wdata are stable for that whole cycle.
- Maximum throughput: 1 word per 5 cycles, i.e. 4 transfers plus 1 WRITE bubble.
- done and the cpu_hold fall occur in the same cycle: the cycle after the final WRITE (or after the checksum transfer). For N = 0 they occur the cycle after the LEN_HI transfer.
- Stalls on rx_valid = 0 are unbounded and lose no state.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - One trailing byte follows the data bytes; the loader waits for it in the CHECK state.
  - The expected value is the XOR of all data bytes; the length bytes are excluded.
  - Match → DONE. Mismatch → ERROR, and cpu_hold stays 1.
  - For N = 0 the checksum byte is still required and must be 0x00.
- Not defined: there is no CHECK state and no trailing byte. The last WRITE goes directly to DONE.

## Structure
- Package `imem_loader_pkg`:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
  - constants: BYTES_PER_WORD = 4, LEN_BYTES = 2.
- Sub-module `byte_packer`:
  - 2-bit byte index plus a shift register assembling little-endian words.
  - Signals word_full when the 4th byte lands; cleared by reset or start.

## Test plan
- Load N=3 words (0x11223344, 0xAABBCCDD, 0x00000013) with rx_valid held high:
  - three mem_we pulses, at addresses 0, 4, 8, with the stated data.
  - done one cycle after the last write; cpu_hold falls with it; words_loaded = 3.
- Same load with rx_valid toggled randomly → identical writes and data; no byte lost or duplicated.
- Header N=2049 (DEPTH=2048):
  - ERROR immediately after the LEN_HI transfer, with no mem_we.
  - error = 1 and cpu_hold = 1.
  - The next start clears error.
- N=0 → done pulses the cycle after LEN_HI; no writes; words_loaded = 0.
- Assert reset after 6 data bytes of an N=4 load:
  - only word 0 has been written.
  - After reset: state IDLE, cpu_hold = 1, and all other outputs at their reset values.
- With IMEM_LOADER_CHECKSUM_EN, N=1, word 0x01020304:
  - checksum byte 0x04 → done.
  - checksum byte 0x05 → error = 1, cpu_hold = 1.
